if_fetch_unit: RTL and testbench

Instruction-fetch stage of the five-stage pipeline. Owns the program counter, issues word-aligned requests to a synchronous instruction memory, and delivers each returned instruction with its PC+4 into the IF/ID pipeline register. Honours hazard-unit stalls without losing in-flight fetches, and honours branch/jump redirects from later stages by squashing wrong-path fetches.

---
 rtl/if_fetch_unit_pkg.sv | 17 +
 rtl/if_fetch_unit_if.sv | 14 +
 rtl/if_fetch_unit_fetch_skid_buf.sv | 58 +++++
 rtl/if_fetch_unit.sv | 124 ++++++++++++
 tb/tb_if_fetch_unit.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/if_fetch_unit_pkg.sv
// Shared constants and types for the instruction-fetch stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package if_fetch_unit_pkg;

  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = '0;
  localparam int PC_INC = 4;

  // What the stage does on the coming edge; redirect outranks stall.
  typedef enum logic [1:0] {
    ACT_NORMAL   = 2'd0,
    ACT_STALL    = 2'd1,
    ACT_REDIRECT = 2'd2
  } fetch_act_e;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response bus between fetch stage and imem.
// Latency: response data valid the cycle after a request.
// Backpressure: none on the bus; the fetch stage withholds requests instead.
// Signals: imem_req / imem_addr (master -> slave), imem_rdata (slave -> master).
interface if_fetch_unit_if #(
  parameter int ADDR_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_rdata);
endinterface

// File: rtl/if_fetch_unit_fetch_skid_buf.sv
// Single-entry buffer holding one fetched instruction across a stall.
// Latency: captured entry visible the cycle after capture_i.
// Backpressure: none; the owner only captures when the entry is free.
// Ports: clk/rst_n; flush_i, capture_i (+instr/pc), release_i; valid/instr/pc out.
module fetch_skid_buf
  import if_fetch_unit_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush_i,
  input  logic               capture_i,
  input  logic               release_i,
  input  logic [INSTR_W-1:0] cap_instr_i,
  input  logic [ADDR_W-1:0]  cap_pc_i,
  output logic               valid_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [ADDR_W-1:0]  pc_o
);

  logic               valid_q, valid_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;

  // Flush beats capture: a redirect discards the wrong-path response.
  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (capture_i) begin
      valid_d = 1'b1;
      instr_d = cap_instr_i;
      pc_d    = cap_pc_i;
    end else if (release_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches from imem, fills IF/ID.
// Latency: 2 cycles from request to instruction on the outputs.
// Backpressure: stall holds PC/outputs, in-flight response parked in a skid entry.
// Ports: clk, reset (async active-low), stall, redirect/redirect_pc,
//        imem bus (master), instr_out/pc_plus4_out/valid_out to IF/ID.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  if_fetch_unit_if.master    imem,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  pc_plus4_out,
  output logic               valid_out
);

  fetch_act_e act;

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               inflight_q, inflight_d;
  logic [ADDR_W-1:0]  inflight_pc_q, inflight_pc_d;
  logic               valid_q, valid_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  pc4_q, pc4_d;

  logic               skid_valid;
  logic [INSTR_W-1:0] skid_instr;
  logic [ADDR_W-1:0]  skid_pc;

  always_comb begin
    if (redirect)   act = ACT_REDIRECT;
    else if (stall) act = ACT_STALL;
    else            act = ACT_NORMAL;
  end

  assign imem.imem_req  = reset & (act == ACT_NORMAL);
  assign imem.imem_addr = pc_q;

  // A response can only be pending in one place: inflight was set by the
  // previous normal cycle, which also drained the skid entry.
  fetch_skid_buf #(.ADDR_W(ADDR_W)) u_skid (
    .clk         (clk),
    .rst_n       (reset),
    .flush_i     (act == ACT_REDIRECT),
    .capture_i   ((act == ACT_STALL) && inflight_q),
    .release_i   ((act == ACT_NORMAL) && skid_valid),
    .cap_instr_i (imem.imem_rdata),
    .cap_pc_i    (inflight_pc_q),
    .valid_o     (skid_valid),
    .instr_o     (skid_instr),
    .pc_o        (skid_pc)
  );

  always_comb begin
    pc_d          = pc_q;
    inflight_d    = inflight_q;
    inflight_pc_d = inflight_pc_q;
    valid_d       = valid_q;
    instr_d       = instr_q;
    pc4_d         = pc4_q;
    case (act)
      ACT_REDIRECT: begin
        // Low two bits of the target are dropped to keep fetches word-aligned.
        pc_d       = redirect_pc & ~ADDR_W'(3);
        inflight_d = 1'b0;
        valid_d    = 1'b0;
        instr_d    = NOP_INSTR;
      end
      ACT_STALL: begin
        inflight_d = 1'b0;
      end
      ACT_NORMAL: begin
        pc_d          = pc_q + ADDR_W'(PC_INC);
        inflight_d    = 1'b1;
        inflight_pc_d = pc_q;
        if (skid_valid) begin
          valid_d = 1'b1;
          instr_d = skid_instr;
          pc4_d   = skid_pc + ADDR_W'(PC_INC);
        end else if (inflight_q) begin
          valid_d = 1'b1;
          instr_d = imem.imem_rdata;
          pc4_d   = inflight_pc_q + ADDR_W'(PC_INC);
        end else begin
          // Bubble: pc_plus4_out keeps its last value.
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
        end
      end
      default: begin
        pc_d = pc_q;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q          <= ADDR_W'(RESET_PC);
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      valid_q       <= 1'b0;
      instr_q       <= NOP_INSTR;
      pc4_q         <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      valid_q       <= valid_d;
      instr_q       <= instr_d;
      pc4_q         <= pc4_d;
    end
  end

  assign valid_out    = valid_q;
  assign instr_out    = instr_q;
  assign pc_plus4_out = pc4_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;
  import if_fetch_unit_pkg::*;

  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instr_out, pc4_out, instr_w, pc4_w;
  logic        valid_out, valid_w;
  logic [31:0] mem_xor;

  int n_vec = 0;
  int n_err = 0;

  if_fetch_unit_if #(.ADDR_W(32)) imem ();
  if_fetch_unit_if #(.ADDR_W(32)) imem_w ();

  if_fetch_unit #(.RESET_PC(32'h0), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem(imem), .instr_out(instr_out),
    .pc_plus4_out(pc4_out), .valid_out(valid_out)
  );

  if_fetch_unit #(.RESET_PC(WRAP_PC), .ADDR_W(32)) dut_w (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem(imem_w), .instr_out(instr_w),
    .pc_plus4_out(pc4_w), .valid_out(valid_w)
  );

  // Synchronous instruction memories: data = address ^ mem_xor.
  always @(posedge clk) if (imem.imem_req)   imem.imem_rdata   <= imem.imem_addr ^ mem_xor;
  always @(posedge clk) if (imem_w.imem_req) imem_w.imem_rdata <= imem_w.imem_addr ^ mem_xor;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic st, input logic rd, input logic [31:0] rpc);
    stall = st; redirect = rd; redirect_pc = rpc;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: fetches issued but not yet delivered, in order.
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid;
  logic [31:0] m_q[$];

  task automatic model_reset();
    m_pc = 32'h0; m_q.delete(); m_valid = 1'b0; m_instr = 32'h0; m_pc4 = 32'h0;
  endtask

  task automatic model_edge(input logic st, input logic rd, input logic [31:0] rpc);
    logic [31:0] a;
    if (rd) begin
      m_q.delete();
      m_pc = rpc & ~32'h3;
      m_valid = 1'b0; m_instr = 32'h0;
    end else if (!st) begin
      if (m_q.size() > 0) begin
        a = m_q.pop_front();
        m_valid = 1'b1; m_instr = a ^ mem_xor; m_pc4 = a + 32'd4;
      end else begin
        m_valid = 1'b0; m_instr = 32'h0;
      end
      m_q.push_back(m_pc);
      m_pc = m_pc + 32'd4;
    end
  endtask

  typedef struct {
    logic        st;
    logic        rd;
    logic [31:0] rpc;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] instr;
    logic [31:0] pc4;
  } vec_t;

  vec_t        tbl[16];
  logic [31:0] wrap_addr[3];

  initial begin
    tbl[0]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h0,   1'b0, 32'h0,   32'h0};
    tbl[1]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h4,   1'b1, 32'h0,   32'h4};
    tbl[2]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h8,   1'b1, 32'h4,   32'h8};
    tbl[3]  = '{1'b1, 1'b0, 32'h0,   1'b0, 32'hC,   1'b1, 32'h4,   32'h8};
    tbl[4]  = '{1'b1, 1'b0, 32'h0,   1'b0, 32'hC,   1'b1, 32'h4,   32'h8};
    tbl[5]  = '{1'b1, 1'b0, 32'h0,   1'b0, 32'hC,   1'b1, 32'h4,   32'h8};
    tbl[6]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'hC,   1'b1, 32'h8,   32'hC};
    tbl[7]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h10,  1'b1, 32'hC,   32'h10};
    tbl[8]  = '{1'b0, 1'b1, 32'h103, 1'b0, 32'h14,  1'b0, 32'h0,   32'h10};
    tbl[9]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 32'h0,   32'h10};
    tbl[10] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h104, 1'b1, 32'h100, 32'h104};
    tbl[11] = '{1'b1, 1'b1, 32'h200, 1'b0, 32'h108, 1'b0, 32'h0,   32'h104};
    tbl[12] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h200, 1'b0, 32'h0,   32'h104};
    tbl[13] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h204, 1'b1, 32'h200, 32'h204};
    tbl[14] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h208, 1'b1, 32'h204, 32'h208};
    tbl[15] = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h20C, 1'b1, 32'h204, 32'h208};
    wrap_addr[0] = 32'hFFFF_FFF8;
    wrap_addr[1] = 32'hFFFF_FFFC;
    wrap_addr[2] = 32'h0000_0000;

    mem_xor = 32'h0;
    reset = 1'b0;
    drive(1'b0, 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req",   {31'b0, imem.imem_req}, 32'h0);
    chk("rst_addr",  imem.imem_addr, 32'h0);
    chk("rst_vld",   {31'b0, valid_out}, 32'h0);
    chk("rst_instr", instr_out, 32'h0);
    chk("rst_pc4",   pc4_out, 32'h0);
    chk("rst_addr_w", imem_w.imem_addr, WRAP_PC);

    // Directed table: startup, 3-cycle stall, redirect, redirect+stall.
    reset = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].st, tbl[i].rd, tbl[i].rpc);
      chk($sformatf("t%0d_req", i), {31'b0, imem.imem_req}, {31'b0, tbl[i].req});
      chk($sformatf("t%0d_addr", i), imem.imem_addr, tbl[i].addr);
      if (i < 3) chk($sformatf("t%0d_addr_w", i), imem_w.imem_addr, wrap_addr[i]);
      tick();
      chk($sformatf("t%0d_vld", i), {31'b0, valid_out}, {31'b0, tbl[i].vld});
      chk($sformatf("t%0d_instr", i), instr_out, tbl[i].instr);
      chk($sformatf("t%0d_pc4", i), pc4_out, tbl[i].pc4);
      if (i == 1) begin
        chk("wrap_instr1", instr_w, 32'hFFFF_FFF8);
        chk("wrap_pc4_1",  pc4_w,   32'hFFFF_FFFC);
      end
      if (i == 2) begin
        chk("wrap_instr2", instr_w, 32'hFFFF_FFFC);
        chk("wrap_pc4_2",  pc4_w,   32'h0);
      end
    end

    // Reset mid-stall with the skid entry holding @0x208.
    reset = 1'b0;
    #1;
    chk("mrst_vld",   {31'b0, valid_out}, 32'h0);
    chk("mrst_instr", instr_out, 32'h0);
    chk("mrst_pc4",   pc4_out, 32'h0);
    chk("mrst_req",   {31'b0, imem.imem_req}, 32'h0);
    chk("mrst_addr",  imem.imem_addr, 32'h0);
    tick();
    reset = 1'b1;
    drive(1'b0, 1'b0, 32'h0);
    chk("mrst_addr0", imem.imem_addr, 32'h0);
    tick();
    chk("mrst_vld0", {31'b0, valid_out}, 32'h0);
    drive(1'b0, 1'b0, 32'h0);
    tick();
    chk("mrst_vld1",   {31'b0, valid_out}, 32'h1);
    chk("mrst_instr1", instr_out, 32'h0);
    chk("mrst_pc4_1",  pc4_out, 32'h4);

    // Randomized run against the reference model.
    reset = 1'b0;
    mem_xor = 32'h5A5A_0000;
    #1;
    model_reset();
    tick();
    reset = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      logic        st, rd;
      logic [31:0] rpc;
      if ($urandom_range(0, 99) < 2) begin
        reset = 1'b0;
        #1;
        model_reset();
        chk("r_rst_vld",   {31'b0, valid_out}, {31'b0, m_valid});
        chk("r_rst_instr", instr_out, m_instr);
        chk("r_rst_pc4",   pc4_out, m_pc4);
        tick();
        reset = 1'b1;
      end else begin
        st  = ($urandom_range(0, 99) < 30);
        rd  = ($urandom_range(0, 99) < 10);
        rpc = $urandom;
        drive(st, rd, rpc);
        chk("r_req",  {31'b0, imem.imem_req}, {31'b0, ~st & ~rd});
        chk("r_addr", imem.imem_addr, m_pc);
        tick();
        model_edge(st, rd, rpc);
        chk("r_vld",   {31'b0, valid_out}, {31'b0, m_valid});
        chk("r_instr", instr_out, m_instr);
        chk("r_pc4",   pc4_out, m_pc4);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
